// File: rtl/id_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction per cycle, resolves operands
// through prioritised forwarding, detects load-use hazards and registers the result for EX.
module id_issue_stage #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int OPT_W   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [31:0]               in_inst,
  output logic [REG_AW-1:0]         rf_rs1,
  output logic [REG_AW-1:0]         rf_rs2,
  input  logic [XLEN-1:0]           rf_r1_data,
  input  logic [XLEN-1:0]           rf_r2_data,
  input  logic [NUM_FWD-1:0]        fwd_wen,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_vd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [OPT_W-1:0]          out_opt,
  output logic [XLEN-1:0]           out_vs1,
  output logic [XLEN-1:0]           out_vs2,
  output logic [REG_AW-1:0]         out_rd,
  output logic [XLEN-1:0]           out_imm,
  output logic                      out_wen,
  output logic                      out_illegal,
  output logic                      hazard_stall
);

  localparam logic [OPT_W-1:0] ZERO_OPT = '0;
  localparam logic [OPT_W-1:0] OPT_LUI = OPT_W'(1),  OPT_AUIPC = OPT_W'(2),  OPT_JAL  = OPT_W'(3);
  localparam logic [OPT_W-1:0] OPT_JALR = OPT_W'(4), OPT_BEQ = OPT_W'(5),    OPT_BNE  = OPT_W'(6);
  localparam logic [OPT_W-1:0] OPT_BLT = OPT_W'(7),  OPT_BGE = OPT_W'(8),    OPT_BLTU = OPT_W'(9);
  localparam logic [OPT_W-1:0] OPT_BGEU = OPT_W'(10), OPT_LB = OPT_W'(11),   OPT_LH   = OPT_W'(12);
  localparam logic [OPT_W-1:0] OPT_LW = OPT_W'(13),  OPT_LBU = OPT_W'(14),   OPT_LHU  = OPT_W'(15);
  localparam logic [OPT_W-1:0] OPT_SB = OPT_W'(16),  OPT_SH = OPT_W'(17),    OPT_SW   = OPT_W'(18);
  localparam logic [OPT_W-1:0] OPT_ADDI = OPT_W'(19), OPT_SLTI = OPT_W'(20), OPT_SLTIU = OPT_W'(21);
  localparam logic [OPT_W-1:0] OPT_XORI = OPT_W'(22), OPT_ORI = OPT_W'(23),  OPT_ANDI = OPT_W'(24);
  localparam logic [OPT_W-1:0] OPT_SLLI = OPT_W'(25), OPT_SRLI = OPT_W'(26), OPT_SRAI = OPT_W'(27);
  localparam logic [OPT_W-1:0] OPT_ADD = OPT_W'(28), OPT_SUB = OPT_W'(29),   OPT_SLL  = OPT_W'(30);
  localparam logic [OPT_W-1:0] OPT_SLT = OPT_W'(31), OPT_SLTU = OPT_W'(32),  OPT_XOR  = OPT_W'(33);
  localparam logic [OPT_W-1:0] OPT_SRL = OPT_W'(34), OPT_SRA = OPT_W'(35),   OPT_OR   = OPT_W'(36);
  localparam logic [OPT_W-1:0] OPT_AND = OPT_W'(37);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [OPT_W-1:0]  opt;
    logic [XLEN-1:0]   vs1;
    logic [XLEN-1:0]   vs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm;
    logic              wen;
    logic              illegal;
  } payload_t;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [REG_AW-1:0] rd_field;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign funct7   = in_inst[31:25];
  assign rd_field = REG_AW'(in_inst[11:7]);
  assign rf_rs1   = REG_AW'(in_inst[19:15]);
  assign rf_rs2   = REG_AW'(in_inst[24:20]);
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  logic [OPT_W-1:0] dec_opt;
  logic [31:0]      dec_imm32;
  logic             dec_wr, dec_ill, use_rs1, use_rs2;

  always_comb begin
    dec_opt   = ZERO_OPT;
    dec_imm32 = '0;
    dec_wr    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    dec_ill   = 1'b0;
    case (opcode)
      7'b0110111: begin dec_opt = OPT_LUI;   dec_imm32 = imm_u; dec_wr = 1'b1; end
      7'b0010111: begin dec_opt = OPT_AUIPC; dec_imm32 = imm_u; dec_wr = 1'b1; end
      7'b1101111: begin dec_opt = OPT_JAL;   dec_imm32 = imm_j; dec_wr = 1'b1; end
      7'b1100111: begin
        if (funct3 == 3'b000) dec_opt = OPT_JALR;
        dec_imm32 = imm_i; dec_wr = 1'b1; use_rs1 = 1'b1;
      end
      7'b1100011: begin
        case (funct3)
          3'b000: dec_opt = OPT_BEQ;  3'b001: dec_opt = OPT_BNE;
          3'b100: dec_opt = OPT_BLT;  3'b101: dec_opt = OPT_BGE;
          3'b110: dec_opt = OPT_BLTU; 3'b111: dec_opt = OPT_BGEU;
          default: dec_opt = ZERO_OPT;
        endcase
        dec_imm32 = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0000011: begin
        case (funct3)
          3'b000: dec_opt = OPT_LB;  3'b001: dec_opt = OPT_LH; 3'b010: dec_opt = OPT_LW;
          3'b100: dec_opt = OPT_LBU; 3'b101: dec_opt = OPT_LHU;
          default: dec_opt = ZERO_OPT;
        endcase
        dec_imm32 = imm_i; dec_wr = 1'b1; use_rs1 = 1'b1;
      end
      7'b0100011: begin
        case (funct3)
          3'b000: dec_opt = OPT_SB; 3'b001: dec_opt = OPT_SH; 3'b010: dec_opt = OPT_SW;
          default: dec_opt = ZERO_OPT;
        endcase
        dec_imm32 = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      7'b0010011: begin
        dec_imm32 = imm_i; dec_wr = 1'b1; use_rs1 = 1'b1;
        case (funct3)
          3'b000: dec_opt = OPT_ADDI; 3'b010: dec_opt = OPT_SLTI; 3'b011: dec_opt = OPT_SLTIU;
          3'b100: dec_opt = OPT_XORI; 3'b110: dec_opt = OPT_ORI;  3'b111: dec_opt = OPT_ANDI;
          3'b001: if (funct7 == 7'h00) dec_opt = OPT_SLLI;
          default: begin
            if (funct7 == 7'h00)      dec_opt = OPT_SRLI;
            else if (funct7 == 7'h20) dec_opt = OPT_SRAI;
          end
        endcase
        // shifts carry the bare shift amount, not the funct7 bits
        if (funct3 == 3'b001 || funct3 == 3'b101) dec_imm32 = {27'b0, in_inst[24:20]};
      end
      7'b0110011: begin
        dec_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: dec_opt = OPT_ADD;  10'b0100000_000: dec_opt = OPT_SUB;
          10'b0000000_001: dec_opt = OPT_SLL;  10'b0000000_010: dec_opt = OPT_SLT;
          10'b0000000_011: dec_opt = OPT_SLTU; 10'b0000000_100: dec_opt = OPT_XOR;
          10'b0000000_101: dec_opt = OPT_SRL;  10'b0100000_101: dec_opt = OPT_SRA;
          10'b0000000_110: dec_opt = OPT_OR;   10'b0000000_111: dec_opt = OPT_AND;
          default: dec_opt = ZERO_OPT;
        endcase
      end
      default: dec_opt = ZERO_OPT;
    endcase
    if (dec_opt == ZERO_OPT) begin
      dec_ill   = 1'b1;
      dec_imm32 = '0;
      dec_wr    = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
    end
  end

  // Returns {hazard, value}; scanning from the oldest source lets index 0 win.
  function automatic logic [XLEN:0] resolve(
    input logic                      use_rs,
    input logic [REG_AW-1:0]         rs,
    input logic [XLEN-1:0]           rf_data,
    input logic [NUM_FWD-1:0]        wen,
    input logic [NUM_FWD-1:0]        is_load,
    input logic [NUM_FWD*REG_AW-1:0] rd,
    input logic [NUM_FWD*XLEN-1:0]   vd
  );
    logic [XLEN:0] r;
    r = '0;
    if (use_rs && rs != '0) begin
      r = {1'b0, rf_data};
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (wen[i] && rd[i*REG_AW +: REG_AW] == rs) r = {is_load[i], vd[i*XLEN +: XLEN]};
      end
    end
    return r;
  endfunction

  logic [XLEN:0] op1, op2;
  logic          advance;
  payload_t      payload_q, payload_d;
  logic          out_valid_q, out_valid_d;

  assign op1 = resolve(use_rs1, rf_rs1, rf_r1_data, fwd_wen, fwd_is_load, fwd_rd, fwd_vd);
  assign op2 = resolve(use_rs2, rf_rs2, rf_r2_data, fwd_wen, fwd_is_load, fwd_rd, fwd_vd);

  assign hazard_stall = in_valid & (op1[XLEN] | op2[XLEN]);
  assign advance      = rdy & (out_ready | ~out_valid_q);
  assign in_ready     = advance & ~hazard_stall & ~flush;

  always_comb begin
    out_valid_d = out_valid_q;
    payload_d   = payload_q;
    if (rdy) begin
      if (flush) begin
        out_valid_d = 1'b0;
      end else if (advance) begin
        if (hazard_stall || !in_valid) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d       = 1'b1;
          payload_d.pc      = in_pc;
          payload_d.opt     = dec_opt;
          payload_d.vs1     = op1[XLEN-1:0];
          payload_d.vs2     = op2[XLEN-1:0];
          payload_d.rd      = (dec_wr && rd_field != '0) ? rd_field : '0;
          payload_d.imm     = XLEN'($signed(dec_imm32));
          payload_d.wen     = dec_wr && rd_field != '0;
          payload_d.illegal = dec_ill;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      payload_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      payload_q   <= payload_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = payload_q.pc;
  assign out_opt     = payload_q.opt;
  assign out_vs1     = payload_q.vs1;
  assign out_vs2     = payload_q.vs2;
  assign out_rd      = payload_q.rd;
  assign out_imm     = payload_q.imm;
  assign out_wen     = payload_q.wen;
  assign out_illegal = payload_q.illegal;

endmodule
